// File: rtl/instr_seq.sv
`default_nettype none
// ============================================================================
//  Module      : instr_seq
//  Description : Instruction sequencer. Takes an opcode word from the MDB,
//                decodes it, collects up to two extension words, and then
//                presents one decoded bundle with a valid/ready handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module instr_seq #(
  parameter int CG_EN        = 1,
  parameter int ILLEGAL_TRAP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        ins_valid,
  input  logic [15:0] ins_word,
  output logic        ins_ready,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [1:0]  format,
  output logic [3:0]  opcode,
  output logic [3:0]  src_reg,
  output logic [3:0]  dst_reg,
  output logic [1:0]  as,
  output logic        ad,
  output logic        bw,
  output logic [15:0] src_ext,
  output logic [15:0] dst_ext,
  output logic [9:0]  jmp_off,
  output logic [1:0]  ext_cnt,
  output logic        cg_used,
  output logic        illegal
);

  localparam logic [1:0] FMT_ILL = 2'd0;
  localparam logic [1:0] FMT_I   = 2'd1;
  localparam logic [1:0] FMT_II  = 2'd2;
  localparam logic [1:0] FMT_JMP = 2'd3;

  typedef enum logic [1:0] {
    ST_OP    = 2'd0,
    ST_SRC   = 2'd1,
    ST_DST   = 2'd2,
    ST_ISSUE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        ins_ready_q, ins_ready_d;
  logic        dec_valid_q, dec_valid_d;
  logic [1:0]  format_q, format_d;
  logic [3:0]  opcode_q, opcode_d;
  logic [3:0]  src_reg_q, src_reg_d;
  logic [3:0]  dst_reg_q, dst_reg_d;
  logic [1:0]  as_q, as_d;
  logic        ad_q, ad_d;
  logic        bw_q, bw_d;
  logic [15:0] src_ext_q, src_ext_d;
  logic [15:0] dst_ext_q, dst_ext_d;
  logic [9:0]  jmp_off_q, jmp_off_d;
  logic [1:0]  ext_cnt_q, ext_cnt_d;
  logic        cg_used_q, cg_used_d;
  logic        illegal_q, illegal_d;

  // Decode of the word currently on the bus (only used when accepted in OP)
  logic [1:0]  op_format;
  logic [3:0]  op_opcode;
  logic [3:0]  op_src;
  logic [3:0]  op_dst;
  logic [1:0]  op_as;
  logic        op_ad;
  logic        op_bw;
  logic [9:0]  op_jmp;
  logic        op_illegal;
  logic        op_is_alu;
  logic        op_cg;
  logic        op_need_src;
  logic        op_need_dst;
  logic        accept;

  // Opcode-word field decode and extension-word requirements
  always_comb begin
    op_format  = FMT_ILL;
    op_opcode  = 4'd0;
    op_src     = 4'd0;
    op_dst     = 4'd0;
    op_as      = 2'd0;
    op_ad      = 1'b0;
    op_bw      = 1'b0;
    op_jmp     = 10'd0;
    op_illegal = 1'b0;
    if (ins_word[15:12] >= 4'd4) begin
      op_format = FMT_I;
      op_opcode = ins_word[15:12];
      op_src    = ins_word[11:8];
      op_ad     = ins_word[7];
      op_bw     = ins_word[6];
      op_as     = ins_word[5:4];
      op_dst    = ins_word[3:0];
    end else if ((ins_word[15:10] == 6'b000100) && (ins_word[9:7] != 3'b111)) begin
      // Single-operand: the one register is both source and destination
      op_format = FMT_II;
      op_opcode = {1'b0, ins_word[9:7]};
      op_bw     = ins_word[6];
      op_as     = ins_word[5:4];
      op_src    = ins_word[3:0];
      op_dst    = ins_word[3:0];
    end else if (ins_word[15:13] == 3'b001) begin
      op_format = FMT_JMP;
      op_opcode = {1'b0, ins_word[12:10]};
      op_jmp    = ins_word[9:0];
    end else begin
      op_illegal = 1'b1;
    end
    op_is_alu   = (op_format == FMT_I) || (op_format == FMT_II);
    // R3 always yields a constant; R2 only in the two indirect modes
    op_cg       = (CG_EN != 0) && op_is_alu &&
                  ((op_src == 4'd3) || ((op_src == 4'd2) && op_as[1]));
    op_need_src = op_is_alu && (((op_as == 2'b01) && !op_cg) ||
                                ((op_as == 2'b11) && (op_src == 4'd0)));
    op_need_dst = (op_format == FMT_I) && op_ad;
  end

  assign accept = ins_valid && ins_ready_q;

  // Next-state and bundle-capture logic
  always_comb begin
    state_d   = state_q;
    format_d  = format_q;
    opcode_d  = opcode_q;
    src_reg_d = src_reg_q;
    dst_reg_d = dst_reg_q;
    as_d      = as_q;
    ad_d      = ad_q;
    bw_d      = bw_q;
    src_ext_d = src_ext_q;
    dst_ext_d = dst_ext_q;
    jmp_off_d = jmp_off_q;
    ext_cnt_d = ext_cnt_q;
    cg_used_d = cg_used_q;
    illegal_d = illegal_q;
    if (flush) begin
      // Abort wins over any accept or consume in the same cycle
      state_d = ST_OP;
    end else begin
      case (state_q)
        ST_OP: begin
          if (accept && !(op_illegal && (ILLEGAL_TRAP == 0))) begin
            format_d  = op_format;
            opcode_d  = op_opcode;
            src_reg_d = op_src;
            dst_reg_d = op_dst;
            as_d      = op_as;
            ad_d      = op_ad;
            bw_d      = op_bw;
            jmp_off_d = op_jmp;
            cg_used_d = op_cg;
            illegal_d = op_illegal;
            src_ext_d = 16'd0;
            dst_ext_d = 16'd0;
            ext_cnt_d = {1'b0, op_need_src} + {1'b0, op_need_dst};
            if (op_need_src)      state_d = ST_SRC;
            else if (op_need_dst) state_d = ST_DST;
            else                  state_d = ST_ISSUE;
          end
        end
        ST_SRC: begin
          if (accept) begin
            src_ext_d = ins_word;
            state_d   = ((format_q == FMT_I) && ad_q) ? ST_DST : ST_ISSUE;
          end
        end
        ST_DST: begin
          if (accept) begin
            dst_ext_d = ins_word;
            state_d   = ST_ISSUE;
          end
        end
        default: begin
          if (dec_ready) state_d = ST_OP;
        end
      endcase
    end
    dec_valid_d = (state_d == ST_ISSUE);
    ins_ready_d = (state_d != ST_ISSUE);
  end

  // State and registered outputs; reset discards any partial instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_OP;
      ins_ready_q <= 1'b1;
      dec_valid_q <= 1'b0;
      format_q    <= 2'd0;
      opcode_q    <= 4'd0;
      src_reg_q   <= 4'd0;
      dst_reg_q   <= 4'd0;
      as_q        <= 2'd0;
      ad_q        <= 1'b0;
      bw_q        <= 1'b0;
      src_ext_q   <= 16'd0;
      dst_ext_q   <= 16'd0;
      jmp_off_q   <= 10'd0;
      ext_cnt_q   <= 2'd0;
      cg_used_q   <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ins_ready_q <= ins_ready_d;
      dec_valid_q <= dec_valid_d;
      format_q    <= format_d;
      opcode_q    <= opcode_d;
      src_reg_q   <= src_reg_d;
      dst_reg_q   <= dst_reg_d;
      as_q        <= as_d;
      ad_q        <= ad_d;
      bw_q        <= bw_d;
      src_ext_q   <= src_ext_d;
      dst_ext_q   <= dst_ext_d;
      jmp_off_q   <= jmp_off_d;
      ext_cnt_q   <= ext_cnt_d;
      cg_used_q   <= cg_used_d;
      illegal_q   <= illegal_d;
    end
  end

  assign ins_ready = ins_ready_q;
  assign dec_valid = dec_valid_q;
  assign format    = format_q;
  assign opcode    = opcode_q;
  assign src_reg   = src_reg_q;
  assign dst_reg   = dst_reg_q;
  assign as        = as_q;
  assign ad        = ad_q;
  assign bw        = bw_q;
  assign src_ext   = src_ext_q;
  assign dst_ext   = dst_ext_q;
  assign jmp_off   = jmp_off_q;
  assign ext_cnt   = ext_cnt_q;
  assign cg_used   = cg_used_q;
  assign illegal   = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_seq
//  Description : Self-checking bench for instr_seq. Instance a uses default
//                parameters, instance b has CG_EN=0, ILLEGAL_TRAP=0; both
//                share stimulus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instr_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        ins_valid = 1'b0;
  logic [15:0] ins_word = 16'd0;
  logic        dec_ready = 1'b0;

  logic        a_ins_ready, a_dec_valid, a_ad, a_bw, a_cg_used, a_illegal;
  logic [1:0]  a_format, a_as, a_ext_cnt;
  logic [3:0]  a_opcode, a_src_reg, a_dst_reg;
  logic [15:0] a_src_ext, a_dst_ext;
  logic [9:0]  a_jmp_off;

  logic        b_ins_ready, b_dec_valid, b_ad, b_bw, b_cg_used, b_illegal;
  logic [1:0]  b_format, b_as, b_ext_cnt;
  logic [3:0]  b_opcode, b_src_reg, b_dst_reg;
  logic [15:0] b_src_ext, b_dst_ext;
  logic [9:0]  b_jmp_off;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  instr_seq dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .ins_valid(ins_valid),
    .ins_word(ins_word), .ins_ready(a_ins_ready), .dec_valid(a_dec_valid),
    .dec_ready(dec_ready), .format(a_format), .opcode(a_opcode),
    .src_reg(a_src_reg), .dst_reg(a_dst_reg), .as(a_as), .ad(a_ad), .bw(a_bw),
    .src_ext(a_src_ext), .dst_ext(a_dst_ext), .jmp_off(a_jmp_off),
    .ext_cnt(a_ext_cnt), .cg_used(a_cg_used), .illegal(a_illegal)
  );

  instr_seq #(.CG_EN(0), .ILLEGAL_TRAP(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .ins_valid(ins_valid),
    .ins_word(ins_word), .ins_ready(b_ins_ready), .dec_valid(b_dec_valid),
    .dec_ready(dec_ready), .format(b_format), .opcode(b_opcode),
    .src_reg(b_src_reg), .dst_reg(b_dst_reg), .as(b_as), .ad(b_ad), .bw(b_bw),
    .src_ext(b_src_ext), .dst_ext(b_dst_ext), .jmp_off(b_jmp_off),
    .ext_cnt(b_ext_cnt), .cg_used(b_cg_used), .illegal(b_illegal)
  );

  typedef struct {
    logic [15:0] word;
    logic [1:0]  fmt;
    logic [3:0]  opc;
    logic [3:0]  src;
    logic [3:0]  dst;
    logic [1:0]  asm;
    logic        ad;
    logic        bw;
    logic        cg;
    logic        ill;
    logic [9:0]  jmp;
  } vec_t;

  localparam int NV = 13;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    //             word      fmt   opc    src    dst    as    ad    bw    cg    ill   jmp
    tbl[0]  = '{16'h4F0E, 2'd1, 4'd4, 4'd15, 4'd14, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0};
    tbl[1]  = '{16'h5445, 2'd1, 4'd5, 4'd4,  4'd5,  2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0};
    tbl[2]  = '{16'h4324, 2'd1, 4'd4, 4'd3,  4'd4,  2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0};
    tbl[3]  = '{16'h4225, 2'd1, 4'd4, 4'd2,  4'd5,  2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0};
    tbl[4]  = '{16'h4317, 2'd1, 4'd4, 4'd3,  4'd7,  2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0};
    tbl[5]  = '{16'h1085, 2'd2, 4'd1, 4'd5,  4'd5,  2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0};
    tbl[6]  = '{16'h1236, 2'd2, 4'd4, 4'd6,  4'd6,  2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0};
    tbl[7]  = '{16'h1380, 2'd0, 4'd0, 4'd0,  4'd0,  2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0};
    tbl[8]  = '{16'h3C05, 2'd3, 4'd7, 4'd0,  4'd0,  2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd5};
    tbl[9]  = '{16'h23FF, 2'd3, 4'd0, 4'd0,  4'd0,  2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h3FF};
    tbl[10] = '{16'h0000, 2'd0, 4'd0, 4'd0,  4'd0,  2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0};
    tbl[11] = '{16'h1103, 2'd2, 4'd2, 4'd3,  4'd3,  2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0};
    tbl[12] = '{16'h4130, 2'd1, 4'd4, 4'd1,  4'd0,  2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0};

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_dec_valid", a_dec_valid, 0);
    chk("rst_ins_ready", a_ins_ready, 1);
    chk("rst_format", a_format, 0);
    chk("rst_ext_cnt", a_ext_cnt, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // MOV #0x1234,&0x0200: three words, SRC then DST
    ins_valid = 1'b1; ins_word = 16'h40B2;
    tick(); ins_word = 16'h1234;
    chk("s3_after_op_valid", a_dec_valid, 0);
    tick(); ins_word = 16'h0200;
    chk("s3_after_src_valid", a_dec_valid, 0);
    tick(); ins_valid = 1'b0;
    chk("s3_valid", a_dec_valid, 1);
    chk("s3_src_ext", a_src_ext, 16'h1234);
    chk("s3_dst_ext", a_dst_ext, 16'h0200);
    chk("s3_ext_cnt", a_ext_cnt, 2);
    chk("s3_as", a_as, 3);
    chk("s3_ad", a_ad, 1);
    chk("s3_dst_reg", a_dst_reg, 2);
    chk("s3_b_ext_cnt", b_ext_cnt, 2);
    dec_ready = 1'b1; tick(); dec_ready = 1'b0;
    chk("s3_release", a_dec_valid, 0);

    // Table of single-word instructions for the default instance
    for (int i = 0; i < NV; i++) begin
      ins_valid = 1'b1; ins_word = tbl[i].word; dec_ready = 1'b0;
      tick(); ins_valid = 1'b0;
      chk($sformatf("v%0d_valid", i), a_dec_valid, 1);
      chk($sformatf("v%0d_ready", i), a_ins_ready, 0);
      chk($sformatf("v%0d_format", i), a_format, tbl[i].fmt);
      chk($sformatf("v%0d_opcode", i), a_opcode, tbl[i].opc);
      chk($sformatf("v%0d_src", i), a_src_reg, tbl[i].src);
      chk($sformatf("v%0d_dst", i), a_dst_reg, tbl[i].dst);
      chk($sformatf("v%0d_as", i), a_as, tbl[i].asm);
      chk($sformatf("v%0d_ad", i), a_ad, tbl[i].ad);
      chk($sformatf("v%0d_bw", i), a_bw, tbl[i].bw);
      chk($sformatf("v%0d_cg", i), a_cg_used, tbl[i].cg);
      chk($sformatf("v%0d_ill", i), a_illegal, tbl[i].ill);
      chk($sformatf("v%0d_jmp", i), a_jmp_off, tbl[i].jmp);
      chk($sformatf("v%0d_extcnt", i), a_ext_cnt, 0);
      chk($sformatf("v%0d_srcext", i), a_src_ext, 0);
      chk($sformatf("v%0d_dstext", i), a_dst_ext, 0);
      dec_ready = 1'b1; tick(); dec_ready = 1'b0;
      chk($sformatf("v%0d_release", i), a_dec_valid, 0);
      pulse_flush();
    end

    // Constant generator: a needs only dst ext, b (CG off) needs both
    ins_valid = 1'b1; ins_word = 16'h4392;
    tick(); ins_word = 16'h0200;
    chk("cg_a_wait", a_dec_valid, 0);
    tick(); ins_word = 16'hBEEF;
    chk("cg_a_valid", a_dec_valid, 1);
    chk("cg_a_cg", a_cg_used, 1);
    chk("cg_a_extcnt", a_ext_cnt, 1);
    chk("cg_a_srcext", a_src_ext, 0);
    chk("cg_a_dstext", a_dst_ext, 16'h0200);
    chk("cg_b_wait", b_dec_valid, 0);
    chk("cg_b_cg", b_cg_used, 0);
    chk("cg_b_srcext", b_src_ext, 16'h0200);
    tick(); ins_valid = 1'b0;
    chk("cg_a_hold", a_dst_ext, 16'h0200);
    chk("cg_b_valid", b_dec_valid, 1);
    chk("cg_b_extcnt", b_ext_cnt, 2);
    chk("cg_b_dstext", b_dst_ext, 16'hBEEF);
    dec_ready = 1'b1; tick(); dec_ready = 1'b0;
    chk("cg_a_release", a_dec_valid, 0);
    chk("cg_b_release", b_dec_valid, 0);

    // Jump held under backpressure while another word is offered
    ins_valid = 1'b1; ins_word = 16'h3C05;
    tick(); ins_word = 16'hFFFF;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("jmp_hold%0d_valid", k), a_dec_valid, 1);
      chk($sformatf("jmp_hold%0d_ready", k), a_ins_ready, 0);
      chk($sformatf("jmp_hold%0d_fmt", k), a_format, 3);
      chk($sformatf("jmp_hold%0d_off", k), a_jmp_off, 5);
    end
    ins_valid = 1'b0; dec_ready = 1'b1;
    tick(); dec_ready = 1'b0;
    chk("jmp_release_valid", a_dec_valid, 0);
    chk("jmp_release_ready", a_ins_ready, 1);

    // Illegal word: trapped in a, dropped in b
    ins_valid = 1'b1; ins_word = 16'h0000;
    tick(); ins_valid = 1'b0;
    chk("ill_a_valid", a_dec_valid, 1);
    chk("ill_a_flag", a_illegal, 1);
    chk("ill_a_fmt", a_format, 0);
    chk("ill_b_valid", b_dec_valid, 0);
    chk("ill_b_ready", b_ins_ready, 1);
    tick();
    chk("ill_b_still", b_dec_valid, 0);
    dec_ready = 1'b1; tick(); dec_ready = 1'b0;

    // Back-to-back throughput: one single-word instruction per 2 cycles
    cnt = 0;
    ins_valid = 1'b1; ins_word = 16'h4F0E; dec_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (a_dec_valid) cnt++;
    end
    ins_valid = 1'b0; dec_ready = 1'b0;
    chk("thru_count", cnt, 3);
    tick();

    // Flush in SRC while the extension word is offered
    ins_valid = 1'b1; ins_word = 16'h40B2;
    tick(); ins_word = 16'h1234; flush = 1'b1;
    tick(); flush = 1'b0; ins_valid = 1'b0;
    chk("fl_valid", a_dec_valid, 0);
    chk("fl_ready", a_ins_ready, 1);
    ins_valid = 1'b1; ins_word = 16'h4F0E;
    tick(); ins_valid = 1'b0;
    chk("fl_next_valid", a_dec_valid, 1);
    chk("fl_next_src", a_src_reg, 15);
    chk("fl_next_srcext", a_src_ext, 0);
    dec_ready = 1'b1; tick(); dec_ready = 1'b0;

    // Reset pulse while waiting in DST
    ins_valid = 1'b1; ins_word = 16'h40B2;
    tick(); ins_word = 16'h1234;
    tick(); ins_valid = 1'b0;
    chk("rd_pre_srcext", a_src_ext, 16'h1234);
    rst_n = 1'b0;
    #1;
    chk("rd_srcext", a_src_ext, 0);
    chk("rd_format", a_format, 0);
    chk("rd_opcode", a_opcode, 0);
    chk("rd_ad", a_ad, 0);
    chk("rd_valid", a_dec_valid, 0);
    chk("rd_ready", a_ins_ready, 1);
    tick(); rst_n = 1'b1;
    tick();
    ins_valid = 1'b1; ins_word = 16'h0200;
    tick(); ins_valid = 1'b0;
    chk("rd_next_valid", a_dec_valid, 1);
    chk("rd_next_ill", a_illegal, 1);
    chk("rd_next_dstext", a_dst_ext, 0);
    dec_ready = 1'b1; tick(); dec_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
